rs_syndrome_rx: RTL and testbench
=================================

RS_SYNDROME_RX -- requirements
Module: rs_syndrome_rx

Interface
REQ-001 SHALL have parameter N, default 15, codeword length in symbols.
REQ-002 SHALL have parameter K, default 9, message length in symbols; NSYN = N-K = 6 syndromes.
REQ-003 SHALL have parameter SYM_W, default 4, symbol width in bits (GF(16), primitive polynomial x^4+x+1).
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  in  1  synchronous abort of the current word.
REQ-007 SHALL have port sym_in  in  SYM_W  received symbol, highest degree (r14) first.
REQ-008 SHALL have port sym_valid  in  1  sym_in is valid.
REQ-009 SHALL have port sym_ready  out  1  block accepts a symbol this cycle.
REQ-010 SHALL have port word_out  out  N*SYM_W  received word, symbol i at bits [4i+3:4i].
REQ-011 SHALL have port syn_out  out  NSYN*SYM_W  S1 at [3:0] through S6 at [23:20].
REQ-012 SHALL have port err_detected  out  1  OR-reduction of all syndromes.
REQ-013 SHALL have port word_valid  out  1  word_out/syn_out/err_detected are valid.
REQ-014 SHALL have port word_ready  in  1  downstream decoder takes the word.
REQ-015 SHALL have port busy  out  1  high in COLLECT or DONE.

Function
REQ-016 SHALL implement states IDLE, COLLECT, DONE; symbol transfer occurs on a cycle with sym_valid && sym_ready.
REQ-017 SHALL drive sym_ready = 1 in IDLE and COLLECT and 0 in DONE.
REQ-018 SHALL, on every transfer, update each Sj <= Sj*alpha^j XOR sym_in for j = 1..6 (Horner; constant GF multiply, no table RAM).
REQ-019 SHALL store the k-th accepted symbol (k = 0..14) at word_out bits [4(14-k)+3 : 4(14-k)].
REQ-020 SHALL take IDLE->COLLECT on the first transfer, with syndromes starting from zero.
REQ-021 SHALL count transfers 0..14 with a 4-bit counter and take COLLECT->DONE on the 15th transfer.
REQ-022 SHALL hold the count, syndromes and word unchanged when sym_valid = 0 mid-word (stall of any length).
REQ-023 SHALL assert word_valid in the cycle after the 15th transfer (latency 1) and hold it only in DONE.
REQ-024 SHALL hold word_out, syn_out and err_detected stable while word_valid = 1 && word_ready = 0.
REQ-025 SHALL take DONE->IDLE on word_valid && word_ready, clear syndromes and count, and raise sym_ready in the following cycle.
REQ-026 SHALL give flush priority over all events in any state: next state IDLE, count, syndromes and word_valid cleared, word_out cleared.
REQ-027 SHALL leave word_out/syn_out undefined in meaning when word_valid = 0; the cleared values (zero) appear after reset or flush.

Reset
REQ-028 SHALL, on rst_n low, immediately force the state to IDLE, count 0, all syndromes 0 and word_out 0.
REQ-029 SHALL, during reset, drive word_valid = 0, err_detected = 0, busy = 0 and sym_ready = 1.
REQ-030 SHALL discard a partially received word on reset mid-word; no word_valid follows the reset.

Structure
REQ-031 SHALL place N, K, SYM_W, NSYN, the alpha^j constants and a GF(16) multiply function in shared package rs_pkg.
REQ-032 SHALL instantiate sub-module rs_syn_cell (one Horner accumulator, parameter j) six times.

Verification
REQ-033 SHALL verify: 15 zero symbols -> word_valid one cycle after the last transfer, syn_out = 24'h000000, err_detected = 0.
REQ-034 SHALL verify: codeword g(x), word_out = 60'h000000001793CAC (symbols 14..0) -> syn_out = 0, err_detected = 0.
REQ-035 SHALL verify: only r1 = 4'h1 -> syn_out = 24'hC63842; only r0 = 4'h1 -> syn_out = 24'h111111; err_detected = 1 in both.
REQ-036 SHALL verify: random sym_valid gaps plus word_ready held low 5 cycles -> identical outputs; sym_ready = 0 throughout DONE.
REQ-037 SHALL verify: flush after 7 symbols, then a full zero word -> syn_out = 0 and exactly one word_valid.
REQ-038 SHALL verify: rst_n pulsed low after 10 symbols -> outputs at reset values and no word_valid until 15 new transfers.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared GF(16) definitions for the RS(15,9) syndrome receiver.
package rs_pkg;

    localparam int N     = 15;
    localparam int K     = 9;
    localparam int SYM_W = 4;
    localparam int NSYN  = N - K;

    // Low-order taps of the primitive polynomial x^4 + x + 1.
    localparam logic [SYM_W-1:0] PRIM_LOW = 4'h3;

    // alpha^j for j = 1..6, alpha^1 in the lowest nibble.
    localparam logic [NSYN*SYM_W-1:0] ALPHA_J = {4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } rx_state_t;

    // Shift-and-add GF(16) multiply; folds to XOR gates when one operand is constant.
    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] t;
        p = '0;
        t = a;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[SYM_W-2:0], 1'b0} ^ (t[SYM_W-1] ? PRIM_LOW : '0);
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_syndrome_rx_if.sv
// Symbol-in / word-out handshake bundle for the syndrome receiver.
interface rs_syndrome_rx_if #(
    parameter int N     = 15,
    parameter int SYM_W = 4,
    parameter int NSYN  = 6
);
    logic [SYM_W-1:0]      sym_in;
    logic                  sym_valid;
    logic                  sym_ready;
    logic [N*SYM_W-1:0]    word_out;
    logic [NSYN*SYM_W-1:0] syn_out;
    logic                  err_detected;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output sym_in, sym_valid, word_ready,
        input  sym_ready, word_out, syn_out, err_detected, word_valid
    );

    modport slave (
        input  sym_in, sym_valid, word_ready,
        output sym_ready, word_out, syn_out, err_detected, word_valid
    );
endinterface

// File: rtl/rs_syn_cell.sv
// One Horner accumulator: S <= S*alpha^j ^ sym on each accepted symbol.
module rs_syn_cell
    import rs_pkg::*;
#(
    parameter int j = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SYM_W-1:0] sym,
    output logic [SYM_W-1:0] syn
);
    localparam logic [SYM_W-1:0] ALPHA = ALPHA_J[(j-1)*SYM_W +: SYM_W];

    // Accumulate the syndrome; clear has priority over an update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syn <= '0;
        end else if (clr) begin
            syn <= '0;
        end else if (en) begin
            syn <= gf_mul(syn, ALPHA) ^ sym;
        end
    end
endmodule

// File: rtl/rs_syndrome_rx.sv
// Collects a 15-symbol RS word and computes its six syndromes on the fly.
module rs_syndrome_rx
    import rs_pkg::*;
#(
    parameter int N     = 15,
    parameter int K     = 9,
    parameter int SYM_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    rs_syndrome_rx_if.slave  bus,
    output logic             busy
);
    localparam int NSYN  = N - K;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    rx_state_t              state;
    logic [CNT_W-1:0]       count;
    logic [N*SYM_W-1:0]     word;
    logic [NSYN*SYM_W-1:0]  syn;
    logic                   valid_q;
    logic                   ready_q;
    logic                   xfer;
    logic                   clr;

    assign xfer = bus.sym_valid && ready_q;
    assign clr  = flush || (state == DONE && bus.word_ready);

    assign bus.sym_ready    = ready_q;
    assign bus.word_valid   = valid_q;
    assign bus.word_out     = word;
    assign bus.syn_out      = syn;
    assign bus.err_detected = |syn;

    for (genvar g = 0; g < NSYN; g++) begin : g_cell
        rs_syn_cell #(.j(g + 1)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (clr),
            .en    (xfer),
            .sym   (bus.sym_in),
            .syn   (syn[g*SYM_W +: SYM_W])
        );
    end

    // Word-assembly FSM with registered handshake outputs; flush overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            word    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            count   <= '0;
            word    <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE, COLLECT: begin
                    if (xfer) begin
                        word[(N - 1 - int'(count))*SYM_W +: SYM_W] <= bus.sym_in;
                        busy <= 1'b1;
                        if (count == LAST) begin
                            state   <= DONE;
                            count   <= '0;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end else begin
                            state <= COLLECT;
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.word_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_syndrome_rx.sv
// Randomized self-checking bench for rs_syndrome_rx against a direct polynomial-evaluation model.
module tb_rs_syndrome_rx;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;

    rs_syndrome_rx_if bus ();

    rs_syndrome_rx #(.N(15), .K(9), .SYM_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0]  exp_tab [0:14];
    int          log_tab [0:15];
    logic [3:0]  cur_syms [0:14];
    logic [59:0] exp_word;
    logic [23:0] exp_syn;

    int   wv_rises = 0;
    logic wv_q     = 1'b0;

    // Count rising edges of word_valid to detect spurious or missing words.
    always @(posedge clk) begin
        if (bus.word_valid === 1'b1 && wv_q !== 1'b1) wv_rises++;
        wv_q = bus.word_valid;
    end

    function automatic logic [3:0] mul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return exp_tab[(log_tab[a] + log_tab[b]) % 15];
    endfunction

    // S_j = sum over i of r_i * alpha^(j*i), r_i being the coefficient of x^i.
    function automatic logic [23:0] model_syn(input logic [59:0] w);
        logic [23:0] s;
        logic [3:0]  acc;
        s = '0;
        for (int jj = 1; jj <= 6; jj++) begin
            acc = 4'h0;
            for (int i = 0; i < 15; i++) acc = acc ^ mul(w[4*i +: 4], exp_tab[(jj*i) % 15]);
            s[4*(jj-1) +: 4] = acc;
        end
        return s;
    endfunction

    task automatic build_tables();
        logic [4:0] v;
        v = 5'd1;
        for (int i = 0; i < 15; i++) begin
            exp_tab[i] = v[3:0];
            log_tab[v[3:0]] = i;
            v = v << 1;
            if (v[4]) v = v ^ 5'h13;
        end
    endtask

    task automatic build_expect();
        for (int k = 0; k < 15; k++) exp_word[(14-k)*4 +: 4] = cur_syms[k];
        exp_syn = model_syn(exp_word);
    endtask

    task automatic random_syms();
        for (int k = 0; k < 15; k++) cur_syms[k] = 4'($urandom_range(0, 15));
    endtask

    task automatic zero_syms();
        for (int k = 0; k < 15; k++) cur_syms[k] = 4'h0;
    endtask

    // Offer symbols first..last with optional random idle gaps; checks word_valid after each transfer.
    task automatic send_symbols(input int first, input int last, input int max_gap);
        int gap;
        int budget;
        for (int k = first; k <= last; k++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            repeat (gap) begin
                bus.sym_valid = 1'b0;
                bus.sym_in    = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
            end
            bus.sym_valid = 1'b1;
            bus.sym_in    = cur_syms[k];
            budget = 0;
            while (bus.sym_ready !== 1'b1 && budget < 50) begin
                @(posedge clk); #1;
                budget++;
            end
            if (budget >= 50) begin
                vectors++; miscompares++;
                $display("FAIL sym_ready_timeout: sym_ready=%b required 1", bus.sym_ready);
            end
            @(posedge clk); #1;
            bus.sym_valid = 1'b0;
            vectors++;
            if (bus.word_valid !== (k == 14)) begin
                miscompares++;
                $display("FAIL word_valid_after_sym%0d: got %b required %b", k, bus.word_valid, (k == 14));
            end
        end
    endtask

    task automatic check_outputs(input string name);
        vectors++;
        if (bus.word_out !== exp_word) begin
            miscompares++;
            $display("FAIL %s word_out: got %h required %h", name, bus.word_out, exp_word);
        end
        vectors++;
        if (bus.syn_out !== exp_syn) begin
            miscompares++;
            $display("FAIL %s syn_out: got %h required %h", name, bus.syn_out, exp_syn);
        end
        vectors++;
        if (bus.err_detected !== (exp_syn != 24'h0)) begin
            miscompares++;
            $display("FAIL %s err_detected: got %b required %b", name, bus.err_detected, (exp_syn != 24'h0));
        end
        vectors++;
        if (bus.word_valid !== 1'b1 || bus.sym_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_flags: valid/ready/busy got %b%b%b required 101", name,
                     bus.word_valid, bus.sym_ready, busy);
        end
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if (bus.word_valid !== 1'b0 || bus.sym_ready !== 1'b1 || busy !== 1'b0 || bus.err_detected !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_flags: valid/ready/busy/err got %b%b%b%b required 0100", name,
                     bus.word_valid, bus.sym_ready, busy, bus.err_detected);
        end
        vectors++;
        if (bus.word_out !== 60'h0 || bus.syn_out !== 24'h0) begin
            miscompares++;
            $display("FAIL %s cleared: word_out=%h syn_out=%h required zero", name, bus.word_out, bus.syn_out);
        end
    endtask

    // Hold word_ready low for 'hold' cycles checking stability, then take the word.
    task automatic accept_word(input int hold);
        bus.word_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            check_outputs("hold");
        end
        bus.word_ready = 1'b1;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
        vectors++;
        if (bus.word_valid !== 1'b0 || bus.sym_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL accept: valid/ready/busy got %b%b%b required 010", bus.word_valid, bus.sym_ready, busy);
        end
        vectors++;
        if (bus.syn_out !== 24'h0) begin
            miscompares++;
            $display("FAIL accept_syn_clear: got %h required 000000", bus.syn_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        bus.sym_valid = 1'b0; bus.sym_in = 4'h0; bus.word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("after_reset");
    endtask

    task automatic test_zero_word();
        zero_syms();
        build_expect();
        send_symbols(0, 14, 0);
        check_outputs("zero_word");
        accept_word(0);
    endtask

    task automatic test_codeword();
        logic [59:0] w;
        w = 60'h000000001793CAC;
        for (int k = 0; k < 15; k++) cur_syms[k] = w[(14-k)*4 +: 4];
        build_expect();
        send_symbols(0, 14, 0);
        check_outputs("codeword");
        vectors++;
        if (bus.syn_out !== 24'h000000 || bus.err_detected !== 1'b0) begin
            miscompares++;
            $display("FAIL codeword_literal: syn_out=%h err=%b required 000000 0", bus.syn_out, bus.err_detected);
        end
        accept_word(1);
    endtask

    task automatic test_single_error();
        zero_syms();
        cur_syms[13] = 4'h1;
        build_expect();
        send_symbols(0, 14, 0);
        check_outputs("r1_only");
        vectors++;
        if (bus.syn_out !== 24'hC63842) begin
            miscompares++;
            $display("FAIL r1_literal: got %h required c63842", bus.syn_out);
        end
        accept_word(0);
        zero_syms();
        cur_syms[14] = 4'h1;
        build_expect();
        send_symbols(0, 14, 0);
        check_outputs("r0_only");
        vectors++;
        if (bus.syn_out !== 24'h111111) begin
            miscompares++;
            $display("FAIL r0_literal: got %h required 111111", bus.syn_out);
        end
        accept_word(0);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            random_syms();
            build_expect();
            send_symbols(0, 14, (n < 2) ? 0 : 3);
            check_outputs("random_word");
            accept_word(5);
        end
    endtask

    task automatic test_flush();
        int base;
        random_syms();
        send_symbols(0, 6, 1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_idle("flush");
        base = wv_rises;
        zero_syms();
        build_expect();
        send_symbols(0, 14, 1);
        check_outputs("after_flush");
        accept_word(2);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wv_rises - base !== 1) begin
            miscompares++;
            $display("FAIL flush_word_count: got %0d words required 1", wv_rises - base);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        random_syms();
        send_symbols(0, 9, 1);
        rst_n = 1'b0;
        #1;
        check_idle("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_idle("reset_released");
        base = wv_rises;
        random_syms();
        build_expect();
        send_symbols(0, 14, 0);
        check_outputs("after_reset_word");
        accept_word(0);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (wv_rises - base !== 1) begin
            miscompares++;
            $display("FAIL reset_word_count: got %0d words required 1", wv_rises - base);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_tables();
        test_reset();
        test_zero_word();
        test_codeword();
        test_single_error();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
